// File: rtl/rv_burst_gatherer_if.sv
// Ready/valid stream bundle with an end-of-burst marker.
// The master drives data/valid/last; the slave answers with ready.
interface rv_burst_gatherer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (output data, valid, last, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/rv_burst_gatherer.sv
// Collects a sparse ready/valid stream into a small FIFO and re-emits it as
// dense bursts of BURST_LEN beats, flagging the final beat of each burst.
// A partial burst is flushed after TIMEOUT idle cycles (TIMEOUT=0 disables).
//
// state  | meaning
// GATHER | collecting beats, output idle, idle timer running while non-empty
// DRAIN  | emitting one burst of burst_rem beats from the FIFO head
module rv_burst_gatherer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                clock_port,
  input  logic                reset_port,
  rv_burst_gatherer_if.slave  input_port,
  rv_burst_gatherer_if.master output_port
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] BURST_C    = CW'(BURST_LEN);
  localparam logic [PW-1:0] PTR_MAX    = PW'(DEPTH - 1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic {
    GATHER = 1'b0,
    DRAIN  = 1'b1
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic [CW-1:0]         burst_rem;
  logic [CW-1:0]         burst_len_nxt;
  logic [IW-1:0]         idle_cnt;
  logic                  valid_q;
  logic                  last_q;
  logic                  in_ready;
  logic                  push;
  logic                  pop;
  logic                  flush;

  // Ready comes only from the registered count, so a pop at full frees a slot next cycle.
  assign in_ready             = (count < DEPTH_C);
  assign input_port.ready     = in_ready;
  assign push                 = input_port.valid & in_ready;
  assign pop                  = valid_q & output_port.ready;
  assign count_nxt            = count + CW'(push) - CW'(pop);
  assign burst_len_nxt        = (count_nxt > BURST_C) ? BURST_C : count_nxt;
  assign flush                = TIMEOUT_EN && (count != '0) && !push && (idle_cnt == IDLE_MAX);

  assign output_port.valid    = valid_q;
  assign output_port.last     = last_q;
  assign output_port.data     = mem[rd_ptr];

  // FIFO storage: written on push, never reset.
  always_ff @(posedge clock_port) begin
    if (push) mem[wr_ptr] <= input_port.data;
  end

  // Pointers and occupancy; pointers wrap explicitly so any DEPTH works.
  always_ff @(posedge clock_port or negedge reset_port) begin
    if (!reset_port) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PW'(1);
    end
  end

  // Burst FSM with registered valid/last; burst size is frozen on entry to DRAIN.
  always_ff @(posedge clock_port or negedge reset_port) begin
    if (!reset_port) begin
      state     <= GATHER;
      idle_cnt  <= '0;
      burst_rem <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      case (state)
        GATHER: begin
          if ((count_nxt >= BURST_C) || flush) begin
            state     <= DRAIN;
            burst_rem <= burst_len_nxt;
            valid_q   <= 1'b1;
            last_q    <= (burst_len_nxt == CW'(1));
            idle_cnt  <= '0;
          end else if (push || (count == '0)) begin
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        DRAIN: begin
          if (pop) begin
            burst_rem <= burst_rem - CW'(1);
            last_q    <= (burst_rem == CW'(2));
            if (last_q) begin
              state    <= GATHER;
              valid_q  <= 1'b0;
              last_q   <= 1'b0;
              idle_cnt <= '0;
            end
          end
        end
        default: state <= GATHER;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_burst_gatherer.sv
// Bench for rv_burst_gatherer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, and a randomized soak.
module tb_rv_burst_gatherer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_burst_gatherer_if #(.DATA_WIDTH(8)) a_in ();
  rv_burst_gatherer_if #(.DATA_WIDTH(8)) a_out ();
  rv_burst_gatherer_if #(.DATA_WIDTH(8)) b_in ();
  rv_burst_gatherer_if #(.DATA_WIDTH(8)) b_out ();

  rv_burst_gatherer #(.DATA_WIDTH(8), .DEPTH(8), .BURST_LEN(4), .TIMEOUT(16)) dut_a (
    .clock_port (clk),
    .reset_port (rst_n),
    .input_port (a_in),
    .output_port(a_out)
  );

  rv_burst_gatherer #(.DATA_WIDTH(8), .DEPTH(8), .BURST_LEN(4), .TIMEOUT(0)) dut_b (
    .clock_port (clk),
    .reset_port (rst_n),
    .input_port (b_in),
    .output_port(b_out)
  );

  logic fixed_rdy;
  logic rand_rdy;
  logic rnd_bit;
  assign a_out.ready = rand_rdy ? rnd_bit : fixed_rdy;
  assign b_out.ready = 1'b1;
  assign a_in.last   = 1'b0;
  assign b_in.last   = 1'b0;

  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of dut_a: a queue of stored beats plus burst bookkeeping.
  logic [7:0] m_q[$];
  bit         m_drain;
  int         m_rem;
  int         m_idle;
  int         m_push_cnt = 0;
  bit         mp_push;
  bit         mp_pop;
  int         mp_before;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_drain = 0;
      m_rem   = 0;
      m_idle  = 0;
    end else begin
      mp_before = m_q.size();
      mp_push   = a_in.valid && (mp_before < 8);
      mp_pop    = m_drain && a_out.ready;
      if (mp_pop) void'(m_q.pop_front());
      if (mp_push) begin
        m_q.push_back(a_in.data);
        m_push_cnt++;
      end
      if (m_drain) begin
        if (mp_pop) begin
          m_rem--;
          if (m_rem == 0) begin
            m_drain = 0;
            m_idle  = 0;
          end
        end
      end else if (m_q.size() >= 4 || (mp_before > 0 && !mp_push && m_idle == 15)) begin
        m_drain = 1;
        m_rem   = (m_q.size() < 4) ? m_q.size() : 4;
        m_idle  = 0;
      end else if (mp_push || mp_before == 0) begin
        m_idle = 0;
      end else begin
        m_idle++;
      end
    end
  end

  // Output monitors: accepted output beats as {last, data}, and stall tracking.
  logic [8:0] mon_q[$];
  logic [8:0] mon_b[$];
  logic       stall_hold = 1'b0;
  logic [7:0] hold_data = '0;

  always @(posedge clk) begin
    if (rst_n && a_out.valid && a_out.ready) mon_q.push_back({a_out.last, a_out.data});
    if (rst_n && b_out.valid && b_out.ready) mon_b.push_back({b_out.last, b_out.data});
    stall_hold <= rst_n && a_out.valid && !a_out.ready;
    hold_data  <= a_out.data;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready", a_in.ready, m_q.size() < 8);
      check("valid", a_out.valid, m_drain);
      check("last", a_out.last, m_drain && (m_rem == 1));
      if (m_drain && m_q.size() > 0) check("data", a_out.data, m_q[0]);
      if (stall_hold) begin
        check("stall_valid", a_out.valid, 1);
        check("stall_data", a_out.data, hold_data);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the beat was accepted, valid still high.
  task automatic push_beat(input logic [7:0] d);
    int n;
    n = 0;
    a_in.valid = 1'b1;
    a_in.data  = d;
    while (!a_in.ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", a_in.ready, 1);
    @(negedge clk);
  endtask

  task automatic wait_mon(input int n, input string name);
    int k;
    k = 0;
    while (mon_q.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, mon_q.size() >= n, 1);
  endtask

  int         base;
  int         n;
  int         pbase;
  logic [7:0] d4 [20];

  initial begin
    a_in.valid = 1'b0;
    a_in.data  = '0;
    b_in.valid = 1'b0;
    b_in.data  = '0;
    fixed_rdy  = 1'b1;
    rand_rdy   = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_valid", a_out.valid, 0);
    check("rst_last", a_out.last, 0);
    check("rst_ready", a_in.ready, 1);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Paced input, one beat per three cycles.
    base = mon_q.size();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("t1_no_early_valid", a_out.valid, 0);
      push_beat(8'(8'h10 + i));
      a_in.valid = 1'b0;
      if (i < 3) repeat (2) @(negedge clk);
    end
    check("t1_valid_next_cycle", a_out.valid, 1);
    check("t1_first_data", a_out.data, 8'h10);
    wait_mon(base + 4, "t1_wait");
    for (int i = 0; i < 4; i++)
      check("t1_beat", mon_q[base + i], {(i == 3), 8'(8'h10 + i)});
    repeat (2) @(negedge clk);

    // Partial burst flushed by the idle timeout.
    base = mon_q.size();
    push_beat(8'hA0);
    push_beat(8'hA1);
    a_in.valid = 1'b0;
    n = 0;
    while (!a_out.valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t2_timeout_cycles", n, 16);
    wait_mon(base + 2, "t2_wait");
    check("t2_beat0", mon_q[base], {1'b0, 8'hA0});
    check("t2_beat1", mon_q[base + 1], {1'b1, 8'hA1});
    repeat (2) @(negedge clk);

    // Fill to full with the consumer stalled, then release.
    base = mon_q.size();
    fixed_rdy = 1'b0;
    for (int i = 0; i < 8; i++) push_beat(8'(i));
    a_in.data = 8'd8;
    check("t3_full_ready", a_in.ready, 0);
    @(negedge clk);
    check("t3_still_full", a_in.ready, 0);
    fixed_rdy = 1'b1;
    @(negedge clk);
    check("t3_ready_after_pop", a_in.ready, 1);
    @(negedge clk);
    a_in.valid = 1'b0;
    wait_mon(base + 9, "t3_wait");
    for (int i = 0; i < 9; i++)
      check("t3_beat", mon_q[base + i], {(i == 3 || i == 7 || i == 8), 8'(i)});
    repeat (2) @(negedge clk);

    // Continuous input against a randomly stalling consumer.
    base = mon_q.size();
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d4[i] = 8'($urandom);
      push_beat(d4[i]);
    end
    a_in.valid = 1'b0;
    wait_mon(base + 20, "t4_wait");
    rand_rdy = 1'b0;
    for (int i = 0; i < 20; i++)
      check("t4_beat", mon_q[base + i], {(i % 4 == 3), d4[i]});
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a burst.
    fixed_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(8'(8'h50 + i));
    a_in.valid = 1'b0;
    @(negedge clk);
    fixed_rdy = 1'b1;
    repeat (2) @(negedge clk);
    fixed_rdy = 1'b0;
    check("t5_pre_valid", a_out.valid, 1);
    check("t5_pre_data", a_out.data, 8'h52);
    check("t5_pre_last", a_out.last, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", a_out.valid, 0);
    check("t5_rst_ready", a_in.ready, 1);
    check("t5_rst_last", a_out.last, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    fixed_rdy = 1'b1;
    base = mon_q.size();
    for (int i = 0; i < 4; i++) push_beat(8'(8'h60 + i));
    a_in.valid = 1'b0;
    wait_mon(base + 4, "t5_wait");
    for (int i = 0; i < 4; i++)
      check("t5_beat", mon_q[base + i], {(i == 3), 8'(8'h60 + i)});

    // TIMEOUT=0 instance never flushes a partial burst.
    base = mon_b.size();
    for (int i = 0; i < 3; i++) begin
      b_in.valid = 1'b1;
      b_in.data  = 8'(8'h70 + i);
      check("t6_ready", b_in.ready, 1);
      @(negedge clk);
    end
    b_in.valid = 1'b0;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (b_out.valid) n++;
    end
    check("t6_no_flush", n, 0);
    b_in.valid = 1'b1;
    b_in.data  = 8'h73;
    @(negedge clk);
    b_in.valid = 1'b0;
    check("t6_valid_next_cycle", b_out.valid, 1);
    n = 0;
    while (mon_b.size() < base + 4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_wait", mon_b.size() >= base + 4, 1);
    for (int i = 0; i < 4; i++)
      check("t6_beat", mon_b[base + i], {(i == 3), 8'(8'h70 + i)});

    // Randomized soak; the model checks every cycle.
    base  = mon_q.size();
    pbase = m_push_cnt;
    rand_rdy = 1'b1;
    repeat (600) begin
      a_in.valid = ($urandom_range(0, 9) < 6);
      a_in.data  = 8'($urandom);
      @(negedge clk);
    end
    a_in.valid = 1'b0;
    rand_rdy   = 1'b0;
    repeat (40) @(negedge clk);
    check("t7_all_out", mon_q.size() - base, m_push_cnt - pbase);
    check("t7_idle_valid", a_out.valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
